gnt_dispatch: RTL

Grant-side consumer for the MSB-first priority encoder. It owns the encoder's enable, captures the one-hot grant it returns, and converts that grant to a binary client index. It then locks the shared memory-write path to the granted client for one complete frame and releases the lock only after the frame's last beat has left its output register. It sits between the N client ports of the memory-separation front end and the single write port into packet memory.

---
 rtl/gnt_dispatch.sv | 81 ++++++++
 1 files changed

// File: rtl/gnt_dispatch.sv
// gnt_dispatch: captures an encoder grant and locks the packet-memory write path to that client for one frame
module gnt_dispatch #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int LW = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  enc_en,
    input  logic [N-1:0]          gnt,
    input  logic [N-1:0]          s_valid,
    input  logic [N*DW-1:0]       s_data,
    input  logic [N-1:0]          s_last,
    output logic [N-1:0]          s_ready,
    output logic                  m_valid,
    output logic [DW-1:0]         m_data,
    output logic                  m_last,
    output logic [$clog2(N)-1:0]  m_idx,
    input  logic                  m_ready,
    output logic                  done,
    output logic [LW-1:0]         done_len,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
    state_t state;
    logic [$clog2(N)-1:0] idx;
    logic [LW-1:0] cnt;
    logic [N-1:0][DW-1:0] s_arr;
    logic acc;
    function automatic logic [$clog2(N)-1:0] hi_idx(input logic [N-1:0] v);
        hi_idx = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) hi_idx = ($clog2(N))'(i);
    endfunction
    assign s_arr   = s_data;
    assign enc_en  = state == IDLE;
    assign s_ready = (state == XFER && (!m_valid || m_ready)) ? N'(1) << idx : '0;
    assign acc     = s_valid[idx] && s_ready[idx];
    // frame FSM, output register, beat counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_idx    <= '0;
            done     <= 1'b0;
            done_len <= '0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (acc) begin
                m_valid <= 1'b1;
                m_data  <= s_arr[idx];
                m_last  <= s_last[idx];
                m_idx   <= idx;
                if (&cnt) err <= 1'b1;
                else cnt <= cnt + LW'(1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: if (|gnt) begin
                    idx   <= hi_idx(gnt);
                    cnt   <= '0;
                    state <= XFER;
                    if (|(gnt & (gnt - N'(1)))) err <= 1'b1;
                end
                XFER: if (acc && s_last[idx]) state <= DRAIN;
                DRAIN: if (m_valid && m_ready) begin
                    done     <= 1'b1;
                    done_len <= cnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
